// File: rtl/relogio_display_mux_if.sv
// rtl/relogio_display_mux_if.sv - time/mode inputs and display pins of the clock display driver
interface relogio_display_mux_if #(
    parameter int N_DIGITS = 8
);
    logic [5:0]          segundos;
    logic [5:0]          minutos;
    logic [5:0]          horas;
    logic [1:0]          modo_ajuste;
    logic [N_DIGITS-1:0] an;
    logic [7:0]          dec_ddp;
    logic [7:0]          leds;

    modport master (
        output segundos, minutos, horas, modo_ajuste,
        input  an, dec_ddp, leds
    );

    modport slave (
        input  segundos, minutos, horas, modo_ajuste,
        output an, dec_ddp, leds
    );
endinterface

// File: rtl/relogio_display_mux.sv
// rtl/relogio_display_mux.sv - multiplexed hh:mm:ss 7-segment scanner with adjust-field marking
// RELOGIO_BLINK_EN selects blinking of the adjust field; otherwise the field is marked by its dp.
module relogio_display_mux #(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic                 clk_100MHz,
    input  logic                 reset,
    relogio_display_mux_if.slave disp
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(N_DIGITS);

    if (!(N_DIGITS == 6 || N_DIGITS == 8)) begin : g_bad_digits
        $error("relogio_display_mux: N_DIGITS must be 6 or 8");
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh
        $error("relogio_display_mux: REFRESH_DIV must be at least 2");
    end
    if (BLINK_DIV < 2) begin : g_bad_blink
        $error("relogio_display_mux: BLINK_DIV must be at least 2");
    end

    logic [RW-1:0]       ref_cnt_q;
    logic [IW-1:0]       idx_q;
    logic [IW-1:0]       cur_q;
    logic                load_q;
    logic [5:0]          sec_q, min_q, hr_q;
    logic [1:0]          mode_snap_q;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [7:0]          dec_q, dec_d;
    logic [7:0]          leds_q, leds_d;
    logic                tick;

    logic [5:0]          field_val;
    logic [1:0]          field;
    logic                over;
    logic [3:0]          tens, units;
    logic [7:0]          digit_seg;
    logic                dp_on;
    logic                mark;

    function automatic logic [7:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    assign tick = (ref_cnt_q == RW'(REFRESH_DIV - 1));

`ifdef RELOGIO_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);

    logic [BW-1:0] blink_cnt_q;
    logic          phase_q;
    logic [1:0]    mode_prev_q;

    // A live mode change restarts the blink so the new field starts visible.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            mode_prev_q <= 2'd0;
        end else begin
            mode_prev_q <= disp.modo_ajuste;
            if (disp.modo_ajuste != mode_prev_q) begin
                blink_cnt_q <= '0;
                phase_q     <= 1'b0;
            end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end
`endif

    // Field code of a digit matches the adjust-mode code that selects it.
    always_comb begin
        field_val = 6'd0;
        field     = 2'd0;
        over      = 1'b0;
        case (cur_q)
            IW'(0), IW'(1): begin
                field_val = sec_q;
                field     = 2'd1;
                over      = (sec_q > 6'd59);
            end
            IW'(2), IW'(3): begin
                field_val = min_q;
                field     = 2'd2;
                over      = (min_q > 6'd59);
            end
            IW'(4), IW'(5): begin
                field_val = hr_q;
                field     = 2'd3;
                over      = (hr_q > 6'd23);
            end
            default: ;
        endcase

        tens  = 4'(field_val / 6'd10);
        units = 4'(field_val % 6'd10);

        if (field == 2'd0) begin
            digit_seg = 8'hFF;
        end else if (over) begin
            digit_seg = 8'hBF;
        end else begin
            digit_seg = seg7(cur_q[0] ? tens : units);
        end

        mark  = (field != 2'd0) && (field == mode_snap_q);
        dp_on = (cur_q == IW'(2)) || (cur_q == IW'(4));
`ifndef RELOGIO_BLINK_EN
        if (mark) begin
            dp_on = 1'b1;
        end
`endif

        dec_d = digit_seg;
        if (field != 2'd0 && dp_on) begin
            dec_d[7] = 1'b0;
        end
`ifdef RELOGIO_BLINK_EN
        if (mark && phase_q) begin
            dec_d = 8'hFF;
        end
`endif
        an_d = ~(N_DIGITS'(1) << cur_q);
    end

    always_comb begin
        case (disp.modo_ajuste)
            2'd1:    leds_d = 8'h01;
            2'd2:    leds_d = 8'h03;
            2'd3:    leds_d = 8'h07;
            default: leds_d = 8'h00;
        endcase
    end

    // Inputs are captured only when the frame restarts at digit 0, so a frame never tears.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            ref_cnt_q   <= '0;
            idx_q       <= '0;
            cur_q       <= '0;
            load_q      <= 1'b0;
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            hr_q        <= 6'd0;
            mode_snap_q <= 2'd0;
            an_q        <= '1;
            dec_q       <= 8'hFF;
            leds_q      <= 8'h00;
        end else begin
            load_q <= tick;
            leds_q <= leds_d;
            if (tick) begin
                ref_cnt_q <= '0;
                cur_q     <= idx_q;
                idx_q     <= (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
                if (idx_q == '0) begin
                    sec_q       <= disp.segundos;
                    min_q       <= disp.minutos;
                    hr_q        <= disp.horas;
                    mode_snap_q <= disp.modo_ajuste;
                end
            end else begin
                ref_cnt_q <= ref_cnt_q + 1'b1;
            end
            if (load_q) begin
                an_q  <= an_d;
                dec_q <= dec_d;
            end
        end
    end

    assign disp.an      = an_q;
    assign disp.dec_ddp = dec_q;
    assign disp.leds    = leds_q;
endmodule

// File: doc/relogio_display_mux.md
# relogio_display_mux

Parametrised multiplexed 7-segment driver for the clock's hh:mm:ss display. It converts binary seconds, minutes and hours to BCD and scans them across `N_DIGITS` common-anode digits. The digit group under adjustment blinks, and an adjust-mode code drives the LEDs. It sits between the time/adjust core and the board's `an`/`dec_ddp`/`leds` pins, replacing the fixed-rate scanner plus combinational LED decode.

## Interface
- `N_DIGITS`, default 8: digits scanned; legal values 6 or 8; digits 6–7 always blank.
- `REFRESH_DIV`, default 100000: clk cycles per digit slot; minimum 2.
- `BLINK_DIV`, default 25000000: clk cycles per blink half-period; minimum 2.
- `clk_100MHz`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-high.
- `segundos`, in, 6: seconds, binary.
- `minutos`, in, 6: minutes, binary.
- `horas`, in, 6: hours, binary.
- `modo_ajuste`, in, 2: 00 normal, 01 seconds, 10 minutes, 11 hours.
- `an`, out, `N_DIGITS`: digit enables, active-low, one-hot-zero.
- `dec_ddp`, out, 8: segments, active-low; bit 7 = dp, bits 6:0 = g..a.
- `leds`, out, 8: adjust-mode indicator.

## Operation
- Reset state: `an` all ones; `dec_ddp` = 8'hFF; `leds` = 8'h00; all counters 0; blink phase 0 (visible); snapshot registers 0.
- Refresh counter runs 0..REFRESH_DIV-1. Its terminal count is the scan tick.
- Each tick advances the digit index. The index wraps from N_DIGITS-1 to 0.
- At each wrap to 0, `segundos`, `minutos`, `horas` and `modo_ajuste` are snapshotted. A frame always shows one coherent time with no tearing.
- Digit map: 0/1 = seconds units/tens; 2/3 = minutes units/tens; 4/5 = hours units/tens; 6/7 = blank (8'hFF).
- Decimal point is lit on digits 2 and 4 as separators. It is blanked together with its digit.
- BCD: tens = value/10, units = value%10, each from a 6-bit value.
- Out-of-range values (seconds or minutes > 59, hours > 23) show a dash on both digits of that field (8'hBF, or 8'h3F where dp is lit).
- Segment codes without dp: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- Blink counter runs 0..BLINK_DIV-1. Its terminal count toggles the blink phase.
- When the phase is 1 and the digit belongs to the snapshotted adjust field, the digit is driven with `an` bit low and `dec_ddp` = 8'hFF.
- Mode 00 never blanks any digit.
- A change of the live `modo_ajuste` from its previous-cycle value clears the blink counter and the phase. The newly selected field is visible first for a full half-period.
- `leds` is registered from the live `modo_ajuste`: 00→8'h00, 01→8'h01, 10→8'h03, 11→8'h07.

## Timing
- `an` and `dec_ddp` are registered. They change in the cycle after the scan tick, and both change in that same cycle.
- First digit output appears REFRESH_DIV+1 cycles after reset release. Until then `an` stays all ones.
- Snapshot latency: an input change is displayed at most one frame (N_DIGITS·REFRESH_DIV cycles) plus one cycle later.
- `leds` latency: one cycle.
- Reset mid-frame returns every output to its reset value asynchronously. Scan restarts at digit 0 after release.
- A mode-change clear of the blink counter and a blink terminal count in the same cycle: the clear wins, and the phase becomes 0.

## Configuration
- `RELOGIO_BLINK_EN`, when defined: the blink counter and the blanking logic are present, as described above.
- When undefined: no blink counter, and the selected field is never blanked. The adjust field is marked instead by lighting the dp on both of its digits, in addition to the separator dp. Mode 00 marks no field. `leds` behaviour is unchanged.

## Test plan
- Reset with REFRESH_DIV=4, N_DIGITS=8 → `an`=8'hFF, `dec_ddp`=8'hFF, `leds`=0. After release, `an` steps FE, FD, FB, … 7F, FE with each value held 4 cycles, first at cycle 5.
- Time 12:34:56, mode 00 → per digit 0..7, `dec_ddp` = 82, 92, 19, B0, 24, F9, FF, FF.
- Inputs changed mid-frame from 59 s to 00 s → digits 0/1 keep showing 9/5 until the next index-0 wrap, then show 0/0. No mixed frame appears.
- Seconds input 60, hours 24 → digits 0/1 show BF/BF and digits 4/5 show 3F/BF.
- RELOGIO_BLINK_EN, BLINK_DIV=16, mode 10 → digits 2/3 are FF for 16 cycles every 32, other digits are unaffected. Switching mode to 11 restarts the phase, and digits 4/5 stay visible for the first 16 cycles.
- Mode sweep 00/01/10/11 → `leds` = 00/01/03/07 one cycle after each change. Without the macro, mode 01 shows digits 0/1 with dp lit (C0 becomes 40).
